// File: rtl/vga_link_pkg.sv
// Shared definitions for the Arduino-to-VGA maze-update link: address map,
// cell state-field codes and link FSM states.
package vga_link_pkg;

    localparam logic [4:0]  ADDR_SYNC = 5'd31;
    localparam logic [4:0]  ADDR_DONE = 5'd30;
    localparam int unsigned NUM_CELLS = 20;
    localparam int unsigned LINK_W    = 9;

    typedef enum logic [2:0] {
        CellUnvisited   = 3'd0,
        CellVisited     = 3'd1,
        CellUnreachable = 3'd2,
        CellRobotN      = 3'd3,
        CellRobotE      = 3'd4,
        CellRobotS      = 3'd5,
        CellRobotW      = 3'd6
    } cell_state_e;

    typedef enum logic [1:0] {
        StIdle,
        StN0,
        StN1,
        StN2
    } link_state_e;

    typedef enum logic [1:0] {
        AddrCell,
        AddrDone,
        AddrSync,
        AddrIllegal
    } addr_class_e;

    function automatic addr_class_e classify_addr(input logic [4:0] addr);
        if (addr == ADDR_SYNC) begin
            return AddrSync;
        end else if (addr == ADDR_DONE) begin
            return AddrDone;
        end else if (addr < 5'(NUM_CELLS)) begin
            return AddrCell;
        end
        return AddrIllegal;
    endfunction

endpackage

// File: rtl/strobe_filter.sv
// Resynchronises the raw link pins and turns each sufficiently long STB high
// period into a single-cycle EVENT, alongside the synced DATA and ADDR fields.
module strobe_filter
    import vga_link_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned STROBE_MIN  = 4
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic [LINK_W-1:0] LINK_IN,
    output logic              EVENT,
    output logic [2:0]        DATA_S,
    output logic [4:0]        ADDR_S
);

    localparam int unsigned CntW = $clog2(STROBE_MIN + 1);

    logic [LINK_W-1:0] sync_q [SYNC_STAGES];
    logic [CntW-1:0]   cnt_q;
    logic              event_q;
    logic              stb_s;

    assign stb_s  = sync_q[SYNC_STAGES-1][5];
    assign DATA_S = sync_q[SYNC_STAGES-1][8:6];
    assign ADDR_S = sync_q[SYNC_STAGES-1][4:0];
    assign EVENT  = event_q;

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
            cnt_q   <= '0;
            event_q <= 1'b0;
        end else begin
            sync_q[0] <= LINK_IN;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            // Count saturates at STROBE_MIN so a long high period fires only once.
            if (!stb_s) begin
                cnt_q <= '0;
            end else if (cnt_q != CntW'(STROBE_MIN)) begin
                cnt_q <= cnt_q + 1'b1;
            end
            event_q <= stb_s && (cnt_q == CntW'(STROBE_MIN - 1));
        end
    end

endmodule

// File: rtl/arduino_link_rx.sv
// Link receiver: assembles three nibbles per cell word, writes the cell RAM,
// tracks the DONE flag and reports aborted or illegal transfers.
module arduino_link_rx
    import vga_link_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned STROBE_MIN  = 4,
    parameter int unsigned TIMEOUT     = 25000,
    parameter int unsigned ERR_W       = 8
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic [LINK_W-1:0] LINK_IN,
    output logic              WR_EN,
    output logic [4:0]        WR_ADDR,
    output logic [8:0]        WR_DATA,
    output logic              DONE,
    output logic              FRAME_ERR,
    output logic [ERR_W-1:0]  ERR_COUNT
);

    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

    logic        evt;
    logic [2:0]  data_s;
    logic [4:0]  addr_s;

    link_state_e state_q;
    logic [4:0]  lat_addr_q;
    logic [5:0]  asm_q;
    logic [TmoW-1:0] tmo_q;
    logic        wr_en_q;
    logic [4:0]  wr_addr_q;
    logic [8:0]  wr_data_q;
    logic        done_q;
    logic        frame_err_q;
    logic [ERR_W-1:0] err_cnt_q;

    addr_class_e cls;
    logic        in_word;
    logic        timeout_hit;
    logic        err;

    strobe_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .STROBE_MIN  (STROBE_MIN)
    ) u_strobe_filter (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .LINK_IN (LINK_IN),
        .EVENT   (evt),
        .DATA_S  (data_s),
        .ADDR_S  (addr_s)
    );

    always_comb begin
        cls         = classify_addr(addr_s);
        in_word     = (state_q == StN1) || (state_q == StN2);
        timeout_hit = in_word && (tmo_q == TmoW'(TIMEOUT - 1));
        err         = 1'b0;
        // An event in the timeout cycle takes priority and cancels the timeout.
        if (evt) begin
            unique case (state_q)
                StN0:       err = (cls == AddrIllegal);
                StN1, StN2: err = (cls == AddrSync) || (addr_s != lat_addr_q);
                default:    err = 1'b0;
            endcase
        end else begin
            err = timeout_hit;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            state_q     <= StIdle;
            lat_addr_q  <= '0;
            asm_q       <= '0;
            tmo_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            wr_en_q     <= 1'b0;
            frame_err_q <= err;
            if (err && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end

            if (evt || !in_word) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end

            if (evt) begin
                if (cls == AddrSync) begin
                    state_q <= StN0;
                end else begin
                    unique case (state_q)
                        StIdle: begin
                        end
                        StN0: begin
                            if (cls == AddrCell) begin
                                lat_addr_q <= addr_s;
                                asm_q[2:0] <= data_s;
                                state_q    <= StN1;
                            end else if (cls == AddrDone) begin
                                done_q <= 1'b1;
                            end else begin
                                state_q <= StIdle;
                            end
                        end
                        StN1: begin
                            if (addr_s == lat_addr_q) begin
                                asm_q[5:3] <= data_s;
                                state_q    <= StN2;
                            end else begin
                                state_q <= StIdle;
                            end
                        end
                        StN2: begin
                            if (addr_s == lat_addr_q) begin
                                wr_data_q <= {data_s, asm_q};
                                wr_addr_q <= lat_addr_q;
                                wr_en_q   <= 1'b1;
                                done_q    <= 1'b0;
                                state_q   <= StN0;
                            end else begin
                                state_q <= StIdle;
                            end
                        end
                        default: state_q <= StIdle;
                    endcase
                end
            end else if (timeout_hit) begin
                state_q <= StIdle;
            end
        end
    end

    assign WR_EN     = wr_en_q;
    assign WR_ADDR   = wr_addr_q;
    assign WR_DATA   = wr_data_q;
    assign DONE      = done_q;
    assign FRAME_ERR = frame_err_q;
    assign ERR_COUNT = err_cnt_q;

endmodule

// File: tb/tb_arduino_link_rx.sv
// Directed self-checking bench for arduino_link_rx at default parameters.
module tb_arduino_link_rx;

    logic       CLOCK = 1'b0;
    logic       RESET_N;
    logic [8:0] LINK_IN;
    logic       WR_EN;
    logic [4:0] WR_ADDR;
    logic [8:0] WR_DATA;
    logic       DONE;
    logic       FRAME_ERR;
    logic [7:0] ERR_COUNT;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int wr_cnt = 0;
    int ferr_cnt = 0;
    int wr_cyc = 0;
    int rise_cyc = 0;
    logic [4:0] last_addr = '0;
    logic [8:0] last_data = '0;

    arduino_link_rx u_dut (
        .CLOCK     (CLOCK),
        .RESET_N   (RESET_N),
        .LINK_IN   (LINK_IN),
        .WR_EN     (WR_EN),
        .WR_ADDR   (WR_ADDR),
        .WR_DATA   (WR_DATA),
        .DONE      (DONE),
        .FRAME_ERR (FRAME_ERR),
        .ERR_COUNT (ERR_COUNT)
    );

    always #20 CLOCK = ~CLOCK;

    always @(posedge CLOCK) cyc <= cyc + 1;

    always @(negedge CLOCK) begin
        if (WR_EN === 1'b1) begin
            wr_cnt    <= wr_cnt + 1;
            last_addr <= WR_ADDR;
            last_data <= WR_DATA;
            wr_cyc    <= cyc;
        end
        if (FRAME_ERR === 1'b1) ferr_cnt <= ferr_cnt + 1;
    end

    // Called at a negedge; raises STB for h cycles then lowers it for l cycles.
    task automatic strobe(input logic [4:0] addr, input logic [2:0] data,
                          input int h = 6, input int l = 4);
        LINK_IN  = {data, 1'b1, addr};
        rise_cyc = cyc;
        repeat (h) @(negedge CLOCK);
        LINK_IN = {data, 1'b0, addr};
        repeat (l) @(negedge CLOCK);
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        LINK_IN = '0;
        repeat (3) @(negedge CLOCK);
        n_cmp++;
        if ({WR_EN, WR_ADDR, WR_DATA, DONE, FRAME_ERR, ERR_COUNT} !== 25'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required all zero",
                     {WR_EN, WR_ADDR, WR_DATA, DONE, FRAME_ERR, ERR_COUNT});
        end
        RESET_N = 1'b1;
        repeat (4) @(negedge CLOCK);
        n_cmp++;
        if ({WR_EN, DONE, FRAME_ERR, ERR_COUNT} !== 11'd0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b required zero",
                     {WR_EN, DONE, FRAME_ERR, ERR_COUNT});
        end
    endtask

    task automatic test_word();
        int w0;
        int f0;
        w0 = wr_cnt;
        f0 = ferr_cnt;
        strobe(5'd31, 3'd0);
        strobe(5'd7, 3'b101);
        strobe(5'd7, 3'b010);
        strobe(5'd7, 3'b001);
        n_cmp++;
        if (wr_cnt - w0 !== 1) begin
            n_fail++;
            $display("FAIL word_wr_count: got %0d required 1", wr_cnt - w0);
        end
        n_cmp++;
        if (last_addr !== 5'd7 || last_data !== 9'b001_010_101) begin
            n_fail++;
            $display("FAIL word_payload: got addr %0d data %b required 7 001010101",
                     last_addr, last_data);
        end
        n_cmp++;
        if (wr_cyc - rise_cyc !== 7) begin
            n_fail++;
            $display("FAIL word_latency: got %0d required 7", wr_cyc - rise_cyc);
        end
        repeat (20) @(negedge CLOCK);
        n_cmp++;
        if (WR_ADDR !== 5'd7 || WR_DATA !== 9'b001_010_101 || ferr_cnt !== f0) begin
            n_fail++;
            $display("FAIL word_hold: got addr %0d data %b errs %0d required 7 001010101 %0d",
                     WR_ADDR, WR_DATA, ferr_cnt, f0);
        end
    endtask

    task automatic test_glitch();
        int w0;
        w0 = wr_cnt;
        strobe(5'd31, 3'd0);
        strobe(5'd9, 3'b110);
        strobe(5'd9, 3'b111, 3, 4);
        strobe(5'd9, 3'b011);
        strobe(5'd9, 3'b100);
        n_cmp++;
        if (wr_cnt - w0 !== 1 || last_data !== 9'b100_011_110 || last_addr !== 5'd9) begin
            n_fail++;
            $display("FAIL glitch_word: got %0d writes data %b addr %0d required 1 100011110 9",
                     wr_cnt - w0, last_data, last_addr);
        end
        n_cmp++;
        if (ERR_COUNT !== 8'd0) begin
            n_fail++;
            $display("FAIL glitch_errcount: got %0d required 0", ERR_COUNT);
        end
    endtask

    task automatic test_bad_addr();
        int w0;
        int f0;
        w0 = wr_cnt;
        f0 = ferr_cnt;
        strobe(5'd31, 3'd0);
        strobe(5'd4, 3'd1);
        strobe(5'd5, 3'd2);
        n_cmp++;
        if (ferr_cnt - f0 !== 1 || ERR_COUNT !== 8'd1 || wr_cnt !== w0) begin
            n_fail++;
            $display("FAIL mismatch_addr: got pulses %0d count %0d writes %0d required 1 1 0",
                     ferr_cnt - f0, ERR_COUNT, wr_cnt - w0);
        end
        strobe(5'd4, 3'd1);
        strobe(5'd4, 3'd2);
        strobe(5'd4, 3'd3);
        n_cmp++;
        if (wr_cnt !== w0 || ERR_COUNT !== 8'd1) begin
            n_fail++;
            $display("FAIL idle_ignores: got writes %0d count %0d required 0 1",
                     wr_cnt - w0, ERR_COUNT);
        end
    endtask

    task automatic test_timeout();
        int w0;
        int f0;
        w0 = wr_cnt;
        f0 = ferr_cnt;
        // Second nibble rises 25001 cycles after the first: one cycle too late.
        strobe(5'd31, 3'd0);
        strobe(5'd2, 3'd5);
        repeat (24991) @(negedge CLOCK);
        strobe(5'd2, 3'd6);
        strobe(5'd2, 3'd7);
        n_cmp++;
        if (ferr_cnt - f0 !== 1 || ERR_COUNT !== 8'd2 || wr_cnt !== w0) begin
            n_fail++;
            $display("FAIL timeout_abort: got pulses %0d count %0d writes %0d required 1 2 0",
                     ferr_cnt - f0, ERR_COUNT, wr_cnt - w0);
        end
        // Third nibble event lands exactly on the timeout cycle.
        f0 = ferr_cnt;
        strobe(5'd31, 3'd0);
        strobe(5'd3, 3'd1);
        strobe(5'd3, 3'd2);
        repeat (24990) @(negedge CLOCK);
        strobe(5'd3, 3'd4);
        n_cmp++;
        if (ferr_cnt !== f0 || wr_cnt - w0 !== 1) begin
            n_fail++;
            $display("FAIL timeout_tie: got pulses %0d writes %0d required 0 1",
                     ferr_cnt - f0, wr_cnt - w0);
        end
        n_cmp++;
        if (last_addr !== 5'd3 || last_data !== 9'b100_010_001) begin
            n_fail++;
            $display("FAIL timeout_tie_word: got addr %0d data %b required 3 100010001",
                     last_addr, last_data);
        end
    endtask

    task automatic test_done();
        int w0;
        w0 = wr_cnt;
        strobe(5'd31, 3'd0);
        strobe(5'd30, 3'd0);
        n_cmp++;
        if (DONE !== 1'b1) begin
            n_fail++;
            $display("FAIL done_set: got %b required 1", DONE);
        end
        strobe(5'd1, 3'd0);
        strobe(5'd31, 3'd0);
        n_cmp++;
        if (DONE !== 1'b1 || ERR_COUNT !== 8'd3) begin
            n_fail++;
            $display("FAIL done_hold_sync_err: got done %b count %0d required 1 3",
                     DONE, ERR_COUNT);
        end
        strobe(5'd19, 3'd6, 4, 4);
        strobe(5'd19, 3'd5, 4, 4);
        strobe(5'd19, 3'd4, 4, 4);
        n_cmp++;
        if (DONE !== 1'b0 || wr_cnt - w0 !== 1 || last_addr !== 5'd19 ||
            last_data !== 9'b100_101_110) begin
            n_fail++;
            $display("FAIL done_clear_word: got done %b writes %0d addr %0d data %b required 0 1 19 100101110",
                     DONE, wr_cnt - w0, last_addr, last_data);
        end
    endtask

    task automatic test_saturate();
        int w0;
        w0 = wr_cnt;
        for (int i = 1; i <= 300; i++) begin
            strobe(5'd31, 3'd0, 5, 3);
            strobe(5'd22, 3'd0, 5, 3);
            if (i == 251) begin
                n_cmp++;
                if (ERR_COUNT !== 8'd254) begin
                    n_fail++;
                    $display("FAIL sat_before: got %0d required 254", ERR_COUNT);
                end
            end
            if (i == 253) begin
                n_cmp++;
                if (ERR_COUNT !== 8'd255) begin
                    n_fail++;
                    $display("FAIL sat_reach: got %0d required 255", ERR_COUNT);
                end
            end
        end
        n_cmp++;
        if (ERR_COUNT !== 8'd255 || wr_cnt !== w0) begin
            n_fail++;
            $display("FAIL sat_hold: got count %0d writes %0d required 255 0",
                     ERR_COUNT, wr_cnt - w0);
        end
    endtask

    task automatic test_reset_mid();
        int w0;
        w0 = wr_cnt;
        strobe(5'd31, 3'd0);
        strobe(5'd8, 3'd7);
        RESET_N = 1'b0;
        repeat (2) @(negedge CLOCK);
        n_cmp++;
        if ({WR_EN, WR_ADDR, WR_DATA, DONE, FRAME_ERR, ERR_COUNT} !== 25'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %b required all zero",
                     {WR_EN, WR_ADDR, WR_DATA, DONE, FRAME_ERR, ERR_COUNT});
        end
        RESET_N = 1'b1;
        strobe(5'd8, 3'd7);
        strobe(5'd8, 3'd7);
        strobe(5'd8, 3'd7);
        n_cmp++;
        if (wr_cnt !== w0 || ERR_COUNT !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_mid_nowrite: got writes %0d count %0d required 0 0",
                     wr_cnt - w0, ERR_COUNT);
        end
    endtask

    initial begin
        RESET_N = 1'b0;
        LINK_IN = '0;
        @(negedge CLOCK);
        test_reset();
        test_word();
        test_glitch();
        test_bad_addr();
        test_timeout();
        test_done();
        test_saturate();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
